vr_shiftreg_ndepth: RTL

- Parametrised successor to the fixed 4-deep valid/ready shift-register buffer.
- Depth, width and almost-full threshold are parameters; adds occupancy count, almost-full flag and synchronous flush.
- Drop-in element for up/down valid/ready pipeline chains, e.g. buffer -> custom logic -> buffer.

---
 rtl/vr_pkg.sv | 27 ++
 rtl/vr_shiftreg_ndepth.sv | 105 ++++++++++
 2 files changed

// File: rtl/vr_pkg.sv
// Shared helpers for the valid/ready shift-register buffers:
// count width derivation and parameter legality checks.
package vr_pkg;

  localparam int MAX_DEPTH = 64;
  localparam int MIN_DEPTH = 2;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

  function automatic bit af_ok(
    input int af,
    input int depth
  );
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit width_ok(input int w);
    return w >= 1;
  endfunction

endpackage

// File: rtl/vr_shiftreg_ndepth.sv
// Parametrised valid/ready shift-register buffer, head at entry 0,
// with occupancy count, almost-full flag and synchronous flush.
module vr_shiftreg_ndepth
  import vr_pkg::*;
#(
  parameter int D_WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int AF_THRESH = 3,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [CNT_W-1:0]   count,
  output logic               almost_full
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("vr_shiftreg_ndepth: DEPTH out of range");
  end
  if (!af_ok(AF_THRESH, DEPTH)) begin : g_bad_af
    $error("vr_shiftreg_ndepth: AF_THRESH out of range");
  end
  if (!width_ok(D_WIDTH)) begin : g_bad_width
    $error("vr_shiftreg_ndepth: D_WIDTH must be positive");
  end

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               af_q;
  logic               af_d;
  logic [CNT_W-1:0]   wr_idx;
  logic               push;
  logic               pop;

  // Ready looks only at registered count, flush and rst.
  assign up_ready = (count_q != FULL_C) & ~flush & ~rst;
  assign down_valid = (count_q != '0);
  assign push = up_valid & up_ready;
  assign pop = down_valid & down_ready;

  assign down_data = mem_q[0];
  assign count = count_q;
  assign almost_full = af_q;

  always_comb begin
    mem_d = mem_q;
    count_d = count_q;
    wr_idx = count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
      wr_idx = count_q - ONE_C;
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr_idx) begin
          mem_d[i] = up_data;
        end
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    // Flush drops occupancy; stale storage is harmless.
    if (flush) begin
      count_d = '0;
    end
    af_d = (count_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      af_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      count_q <= count_d;
      af_q <= af_d;
    end
  end

  a_cnt_max: assert property (
    @(posedge clk) disable iff (rst) count_q <= FULL_C
  );

endmodule
